// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM access arbiter: FSM state and grant owner encodings.
package sram_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_DONE} arb_state_t;
  typedef enum logic {OWN_CPU = 1'b0, OWN_LDR = 1'b1} arb_owner_t;

endpackage

// File: rtl/sram_access_arbiter_if.sv
// Requester-side req/ack handshake bundle; one instance each for the CPU and the loader port.
interface sram_access_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/sram_arb_pick.sv
// Combinational two-way picker: fixed CPU priority or round-robin against the last owner.
module sram_arb_pick
  import sram_arb_pkg::*;
#(
  parameter bit CPU_PRIORITY = 1'b0
) (
  input  logic       cpu_req,
  input  logic       ldr_req,
  input  arb_owner_t last_owner,
  output logic       gnt_vld,
  output arb_owner_t gnt_id
);

  always_comb begin
    gnt_vld = cpu_req | ldr_req;
    gnt_id  = OWN_CPU;
    if (cpu_req && ldr_req) begin
      if (CPU_PRIORITY) gnt_id = OWN_CPU;
      else              gnt_id = (last_owner == OWN_CPU) ? OWN_LDR : OWN_CPU;
    end else if (ldr_req) begin
      gnt_id = OWN_LDR;
    end
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares one async SRAM between the CPU and loader ports: grant, fixed-length strobe window,
// then a one-cycle ack. All SRAM strobes come straight from flops so they drop on reset.
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 2,
  parameter bit CPU_PRIORITY  = 1'b0
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  sram_access_arbiter_if.slave   cpu,
  sram_access_arbiter_if.slave   ldr,
  output logic                   Mem_CE,
  output logic                   Mem_UB,
  output logic                   Mem_LB,
  output logic                   Mem_OE,
  output logic                   Mem_WE,
  output logic [ADDR_W-1:0]      Mem_ADDR,
  output logic [DATA_W-1:0]      Mem_Dout,
  output logic                   Mem_Dout_en,
  input  logic [DATA_W-1:0]      Mem_Din,
  output logic                   busy,
  output logic                   owner
);

  localparam int              CW       = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(ACCESS_CYCLES - 1);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ce_q, ce_d, oe_q, oe_d, wen_q, wen_d, dout_en_q, dout_en_d;
  logic              cpu_ack_q, cpu_ack_d, ldr_ack_q, ldr_ack_d, busy_q, busy_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, ldr_rdata_q, ldr_rdata_d;

  logic              gnt_vld;
  arb_owner_t        gnt_id;
  logic              sel_we;

  sram_arb_pick #(.CPU_PRIORITY(CPU_PRIORITY)) u_pick (
    .cpu_req    (cpu.req),
    .ldr_req    (ldr.req),
    .last_owner (owner_q),
    .gnt_vld    (gnt_vld),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ce_d        = ce_q;
    oe_d        = oe_q;
    wen_d       = wen_q;
    dout_en_d   = dout_en_q;
    busy_d      = busy_q;
    cpu_ack_d   = 1'b0;
    ldr_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    sel_we      = (gnt_id == OWN_LDR) ? ldr.we : cpu.we;

    case (state_q)
      ARB_IDLE: begin
        if (gnt_vld) begin
          owner_d   = gnt_id;
          we_d      = sel_we;
          addr_d    = (gnt_id == OWN_LDR) ? ldr.addr  : cpu.addr;
          wdata_d   = (gnt_id == OWN_LDR) ? ldr.wdata : cpu.wdata;
          cnt_d     = '0;
          busy_d    = 1'b1;
          ce_d      = 1'b0;
          oe_d      = sel_we;
          wen_d     = ~sel_we;
          dout_en_d = sel_we;
          state_d   = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          // Strobes release here; write data stays driven one more cycle for hold time.
          ce_d    = 1'b1;
          oe_d    = 1'b1;
          wen_d   = 1'b1;
          state_d = ARB_DONE;
          if (owner_q == OWN_LDR) begin
            ldr_ack_d = 1'b1;
            if (!we_q) ldr_rdata_d = Mem_Din;
          end else begin
            cpu_ack_d = 1'b1;
            if (!we_q) cpu_rdata_d = Mem_Din;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ARB_DONE: begin
        dout_en_d = 1'b0;
        busy_d    = 1'b0;
        cnt_d     = '0;
        state_d   = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_LDR;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ce_q        <= 1'b1;
      oe_q        <= 1'b1;
      wen_q       <= 1'b1;
      dout_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ce_q        <= ce_d;
      oe_q        <= oe_d;
      wen_q       <= wen_d;
      dout_en_q   <= dout_en_d;
      busy_q      <= busy_d;
      cpu_ack_q   <= cpu_ack_d;
      ldr_ack_q   <= ldr_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  assign Mem_CE      = ce_q;
  assign Mem_UB      = ce_q;
  assign Mem_LB      = ce_q;
  assign Mem_OE      = oe_q;
  assign Mem_WE      = wen_q;
  assign Mem_ADDR    = addr_q;
  assign Mem_Dout    = wdata_q;
  assign Mem_Dout_en = dout_en_q;
  assign busy        = busy_q;
  assign owner       = owner_q;
  assign cpu.ack     = cpu_ack_q;
  assign cpu.rdata   = cpu_rdata_q;
  assign ldr.ack     = ldr_ack_q;
  assign ldr.rdata   = ldr_rdata_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench: DUT0 round-robin with a tiny SRAM model, DUT1 with CPU priority.
module tb_sram_access_arbiter;

  logic Clk, Reset_n;
  int checks = 0;
  int errors = 0;

  sram_access_arbiter_if #(.ADDR_W(20), .DATA_W(16)) cpu0 ();
  sram_access_arbiter_if #(.ADDR_W(20), .DATA_W(16)) ldr0 ();
  sram_access_arbiter_if #(.ADDR_W(20), .DATA_W(16)) cpu1 ();
  sram_access_arbiter_if #(.ADDR_W(20), .DATA_W(16)) ldr1 ();

  logic        m0_ce, m0_ub, m0_lb, m0_oe, m0_we, m0_en, m0_busy, m0_owner;
  logic [19:0] m0_addr;
  logic [15:0] m0_dout, m0_din;
  logic        m1_ce, m1_ub, m1_lb, m1_oe, m1_we, m1_en, m1_busy, m1_owner;
  logic [19:0] m1_addr;
  logic [15:0] m1_dout, m1_din;

  sram_access_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(2), .CPU_PRIORITY(1'b0)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .cpu(cpu0), .ldr(ldr0),
    .Mem_CE(m0_ce), .Mem_UB(m0_ub), .Mem_LB(m0_lb), .Mem_OE(m0_oe), .Mem_WE(m0_we),
    .Mem_ADDR(m0_addr), .Mem_Dout(m0_dout), .Mem_Dout_en(m0_en), .Mem_Din(m0_din),
    .busy(m0_busy), .owner(m0_owner)
  );

  sram_access_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(2), .CPU_PRIORITY(1'b1)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .cpu(cpu1), .ldr(ldr1),
    .Mem_CE(m1_ce), .Mem_UB(m1_ub), .Mem_LB(m1_lb), .Mem_OE(m1_oe), .Mem_WE(m1_we),
    .Mem_ADDR(m1_addr), .Mem_Dout(m1_dout), .Mem_Dout_en(m1_en), .Mem_Din(m1_din),
    .busy(m1_busy), .owner(m1_owner)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Small SRAM model for DUT0: 0x12 preloaded with BEEF, writes land while CE and WE are low.
  logic [15:0] mem [0:255];
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                 mem[8'h12] <= 16'hBEEF;
    else if (!m0_ce && !m0_we)    mem[m0_addr[7:0]] <= m0_dout;
  end
  assign m0_din = (!m0_ce && !m0_oe) ? mem[m0_addr[7:0]] : 16'h0000;
  assign m1_din = (!m1_ce && !m1_oe) ? 16'hA5A5 : 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0;
    cpu0.req = 0; cpu0.we = 0; cpu0.addr = '0; cpu0.wdata = '0;
    ldr0.req = 0; ldr0.we = 0; ldr0.addr = '0; ldr0.wdata = '0;
    cpu1.req = 0; cpu1.we = 0; cpu1.addr = '0; cpu1.wdata = '0;
    ldr1.req = 0; ldr1.we = 0; ldr1.addr = '0; ldr1.wdata = '0;

    // Reset state
    repeat (2) @(negedge Clk);
    chk("rst_ce", m0_ce, 1); chk("rst_ub", m0_ub, 1); chk("rst_lb", m0_lb, 1);
    chk("rst_oe", m0_oe, 1); chk("rst_we", m0_we, 1); chk("rst_addr", m0_addr, 0);
    chk("rst_dout", m0_dout, 0); chk("rst_en", m0_en, 0); chk("rst_cack", cpu0.ack, 0);
    chk("rst_lack", ldr0.ack, 0); chk("rst_crd", cpu0.rdata, 0); chk("rst_busy", m0_busy, 0);
    chk("rst_owner", m0_owner, 1); chk("rst1_ce", m1_ce, 1);
    Reset_n = 1'b1;

    // CPU read of 0x12
    @(negedge Clk); cpu0.addr = 20'h00012; cpu0.we = 0; cpu0.req = 1;
    @(negedge Clk);
    chk("rd_oe1", m0_oe, 0); chk("rd_we1", m0_we, 1); chk("rd_ce1", m0_ce, 0);
    chk("rd_addr", m0_addr, 20'h12); chk("rd_busy", m0_busy, 1); chk("rd_owner", m0_owner, 0);
    chk("rd_en1", m0_en, 0); chk("rd_ack1", cpu0.ack, 0);
    @(negedge Clk);
    chk("rd_oe2", m0_oe, 0); chk("rd_we2", m0_we, 1); chk("rd_ack2", cpu0.ack, 0);
    @(negedge Clk);
    chk("rd_ack3", cpu0.ack, 1); chk("rd_data", cpu0.rdata, 16'hBEEF);
    chk("rd_oe3", m0_oe, 1); chk("rd_ce3", m0_ce, 1); chk("rd_lack3", ldr0.ack, 0);
    cpu0.req = 0;
    @(negedge Clk);
    chk("rd_ack4", cpu0.ack, 0); chk("rd_busy4", m0_busy, 0);

    // Loader write 0x1234 @ 0x40, then CPU read-back
    ldr0.addr = 20'h00040; ldr0.wdata = 16'h1234; ldr0.we = 1; ldr0.req = 1;
    @(negedge Clk);
    chk("wr_we1", m0_we, 0); chk("wr_oe1", m0_oe, 1); chk("wr_dout", m0_dout, 16'h1234);
    chk("wr_en1", m0_en, 1); chk("wr_owner", m0_owner, 1); chk("wr_addr", m0_addr, 20'h40);
    @(negedge Clk);
    chk("wr_we2", m0_we, 0); chk("wr_ack2", ldr0.ack, 0);
    @(negedge Clk);
    chk("wr_ack3", ldr0.ack, 1); chk("wr_we3", m0_we, 1); chk("wr_en3", m0_en, 1);
    chk("wr_ce3", m0_ce, 1);
    ldr0.req = 0; ldr0.we = 0;
    @(negedge Clk);
    chk("wr_en4", m0_en, 0); chk("wr_ack4", ldr0.ack, 0);
    cpu0.addr = 20'h00040; cpu0.req = 1;
    repeat (3) @(negedge Clk);
    chk("rb_ack", cpu0.ack, 1); chk("rb_data", cpu0.rdata, 16'h1234);
    cpu0.req = 0;
    @(negedge Clk);

    // Reset in the middle of a loader write
    ldr0.addr = 20'h00080; ldr0.wdata = 16'h5555; ldr0.we = 1; ldr0.req = 1;
    @(negedge Clk);
    chk("ab_we_pre", m0_we, 0);
    Reset_n = 1'b0;
    #1;
    chk("ab_we", m0_we, 1); chk("ab_ce", m0_ce, 1); chk("ab_en", m0_en, 0);
    chk("ab_lack", ldr0.ack, 0); chk("ab_busy", m0_busy, 0);
    ldr0.req = 0; ldr0.we = 0;
    @(negedge Clk);
    chk("ab_lack2", ldr0.ack, 0); chk("ab_owner", m0_owner, 1);
    Reset_n = 1'b1;

    // Round-robin tie: CPU reads 0x12, loader reads 0x40, both held
    @(negedge Clk);
    cpu0.addr = 20'h00012; cpu0.we = 0; cpu0.req = 1;
    ldr0.addr = 20'h00040; ldr0.we = 0; ldr0.req = 1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge Clk);
      chk($sformatf("rr_cack_%0d", k), cpu0.ack, 32'(k == 3 || k == 11));
      chk($sformatf("rr_lack_%0d", k), ldr0.ack, 32'(k == 7 || k == 15));
      if (k == 1) chk("rr_own1", m0_owner, 0);
      if (k == 5) chk("rr_own5", m0_owner, 1);
      if (k == 3 || k == 11) chk($sformatf("rr_cdata_%0d", k), cpu0.rdata, 16'hBEEF);
      if (k == 7 || k == 15) chk($sformatf("rr_ldata_%0d", k), ldr0.rdata, 16'h1234);
      if (k == 16) begin cpu0.req = 0; ldr0.req = 0; end
    end
    repeat (2) @(negedge Clk);

    // Address changed and req dropped during ACCESS
    cpu0.addr = 20'h00012; cpu0.req = 1;
    @(negedge Clk);
    chk("chg_addr1", m0_addr, 20'h12);
    cpu0.addr = 20'h00099; cpu0.req = 0;
    @(negedge Clk);
    chk("chg_addr2", m0_addr, 20'h12); chk("chg_oe2", m0_oe, 0);
    @(negedge Clk);
    chk("chg_ack", cpu0.ack, 1); chk("chg_data", cpu0.rdata, 16'hBEEF);
    @(negedge Clk);
    chk("chg_ack4", cpu0.ack, 0); chk("chg_busy4", m0_busy, 0);

    // CPU priority tie on DUT1
    cpu1.addr = 20'h00001; cpu1.we = 0; cpu1.req = 1;
    ldr1.addr = 20'h00002; ldr1.we = 0; ldr1.req = 1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge Clk);
      chk($sformatf("pr_cack_%0d", k), cpu1.ack, 32'(k == 3 || k == 7 || k == 11));
      chk($sformatf("pr_lack_%0d", k), ldr1.ack, 32'(k == 15));
      if (k == 3)  chk("pr_cdata", cpu1.rdata, 16'hA5A5);
      if (k == 15) chk("pr_ldata", ldr1.rdata, 16'hA5A5);
      if (k == 13) chk("pr_own13", m1_owner, 1);
      if (k == 11) cpu1.req = 0;
      if (k == 15) ldr1.req = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
